multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM for the RV32I subset core: addi, add/and, lw, sw, beq. It sequences one shared datapath through FETCH, DECODE, EXEC, MEM and WB. It drives the same control-signal set as the single-cycle decoder, plus IR/PC write enables. It handshakes with variable-latency instruction and data memories and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- Opcode  in  7  instruction[6:0]; valid from the cycle after IRWrite
- imem_ready  in  1  instruction memory has data; sampled only while imem_req=1
- dmem_ready  in  1  data memory access complete; sampled only while MemRead|MemWrite=1
- imem_req  out  1  instruction fetch request
- IRWrite  out  1  latch instruction register
- PCWrite  out  1  unconditional PC <= PC+4
- ALUSrc  out  1  0: rs2; 1: immediate
- MemtoReg  out  1  0: ALU result; 1: memory data to register write port
- RegWrite  out  1  register file write enable
- MemRead  out  1  data memory read request
- MemWrite  out  1  data memory write request
- ALUOp  out  2  00: add (lw/sw); 01: branch compare; 10: R/I funct decode
- Branch  out  1  datapath takes branch if Branch & Zero
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- illegal_instr  out  1  trap indicator (see Configuration)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP (TRAP exists only with the macro).
- FETCH: imem_req=1.
  - Hold while imem_ready=0.
  - On imem_ready=1, pulse IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE: latch Opcode into an internal register opc_q; all outputs 0. Next state:
  - 0110011 (R) or 0010011 (I): EXEC
  - 0000011 (LW) or 0100011 (SW): EXEC
  - 1100011 (BR): EXEC
  - any other opcode: per Configuration
- EXEC: decode from opc_q only.
  - R: ALUOp=10, ALUSrc=0; go to WB.
  - I: ALUOp=10, ALUSrc=1; go to WB.
  - LW/SW: ALUOp=00, ALUSrc=1; go to MEM.
  - BR: ALUOp=01, ALUSrc=0, Branch=1, retire=1; go to FETCH.
- MEM: ALUSrc=1 and ALUOp=00 held. LW asserts MemRead; SW asserts MemWrite.
  - Hold while dmem_ready=0.
  - On dmem_ready: LW goes to WB; SW pulses retire and goes to FETCH.
- WB: RegWrite=1, retire=1, go to FETCH.
  - MemtoReg=1 for LW, 0 for R/I.
  - ALUSrc and ALUOp hold their EXEC values so the ALU result stays stable.
- instret increments by 1 on every retire pulse and wraps from 2^CNT_W-1 to 0.
- All outputs are Moore-decoded from state and opc_q. Exception: IRWrite/PCWrite are gated by imem_ready.

## Timing
- Reset:
  - state=FETCH, opc_q=0, instret=0, illegal_instr=0.
  - All control outputs 0 during reset.
  - imem_req=1 from the first cycle after reset deasserts.
- Zero-wait latencies (cycles from FETCH entry to FETCH re-entry): BR 3, R/I 4, SW 4, LW 5. Each memory wait cycle adds 1.
- retire asserts in the final cycle of each instruction; it is never high on two consecutive cycles.
- A ready input that is high while its request is low is ignored and has no effect on state.
- Reset asserted mid-FETCH or mid-MEM aborts the access: requests drop in the reset cycle and no retire occurs. The memories must tolerate an abandoned request.
- Opcode changes outside DECODE have no effect.

## Configuration
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE moves to TRAP.
  - TRAP: illegal_instr=1 and all other outputs 0.
  - The FSM stays in TRAP until reset; no retire occurs.
- Undefined:
  - Unsupported opcode is a NOP: DECODE goes to FETCH with retire=1.
  - illegal_instr is tied 0.
  - The TRAP state is not compiled.

## Structure
- Package mc_ctrl_pkg holds:
  - state_t enum
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BR
  - ALUOp constants ALUOP_ADD=00, ALUOP_BR=01, ALUOP_FUNCT=10
- Sub-module instr_class_decode: combinational; maps a 7-bit opcode to a class enum (R, I, LD, ST, BR, ILL). The FSM uses the class, never raw opcodes.
- The retire counter stays inline in multicycle_controller.

## Test plan
- addi (0010011), both readies tied 1 → IRWrite cycle 0; EXEC ALUSrc=1 ALUOp=10; WB RegWrite=1 MemtoReg=0 at cycle 3; retire at cycle 3; instret=1.
- lw with dmem_ready low 3 cycles → MemRead high 4 cycles; WB MemtoReg=1 RegWrite=1; 8 cycles total; single retire.
- sw then beq, readies=1 → SW retires at cycle 3 with MemWrite=1 and RegWrite=0; BR Branch=1 ALUOp=01 at cycle 6; instret=2.
- imem_ready low 5 cycles after reset, dmem_ready pulsed high during FETCH → imem_req held with no IRWrite; stray dmem_ready ignored; fetch completes on imem_ready.
- Opcode 1111111 → with macro: TRAP, illegal_instr=1, stuck until reset. Without macro: retire at the DECODE cycle, back to FETCH.
- Reset during lw MEM wait → next cycle all outputs 0, instret unchanged (0 after reset), FSM in FETCH. Preload instret to 2^32-1 and retire once → wraps to 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle control FSM.
// TRAP state exists only when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_ILL
  } iclass_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle FSM and datapath/memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       Opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             IRWrite;
  logic             PCWrite;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       ALUOp;
  logic             Branch;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             illegal_instr;

  modport master (
    input  Opcode, imem_ready, dmem_ready,
    output imem_req, IRWrite, PCWrite,
    output ALUSrc, MemtoReg, RegWrite,
    output MemRead, MemWrite, ALUOp,
    output Branch, retire, instret,
    output illegal_instr
  );

  modport slave (
    output Opcode, imem_ready, dmem_ready,
    input  imem_req, IRWrite, PCWrite,
    input  ALUSrc, MemtoReg, RegWrite,
    input  MemRead, MemWrite, ALUOp,
    input  Branch, retire, instret,
    input  illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_instr_class_decode.sv
// instr_class_decode: maps a 7-bit RV32I opcode to an instruction class.
// Anything outside the supported subset is classed CL_ILL.
module instr_class_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls
);
  always_comb begin
    cls = CL_ILL;
    unique case (opcode)
      OP_R:    cls = CL_R;
      OP_I:    cls = CL_I;
      OP_LW:   cls = CL_LD;
      OP_SW:   cls = CL_ST;
      OP_BR:   cls = CL_BR;
      default: cls = CL_ILL;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer + instret.
// MULTICYCLE_ILLEGAL_TRAP_EN: unsupported opcodes trap instead of NOP.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [6:0]       opc_q;
  logic [CNT_W-1:0] instret_q;
  iclass_t          new_cls;
  iclass_t          cur_cls;

  logic       req, irw, pcw, src, m2r;
  logic       rw, mr, mw, brn, ret, ill;
  logic [1:0] aluop;

  instr_class_decode u_new_cls (
    .opcode(bus.Opcode),
    .cls   (new_cls)
  );

  instr_class_decode u_cur_cls (
    .opcode(opc_q),
    .cls   (cur_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      opc_q <= '0;
    end else begin
      case (state)
        FETCH:
          if (bus.imem_ready) state <= DECODE;
        DECODE: begin
          opc_q <= bus.Opcode;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state <= (new_cls == CL_ILL) ? TRAP : EXEC;
`else
          state <= (new_cls == CL_ILL) ? FETCH : EXEC;
`endif
        end
        EXEC:
          case (cur_cls)
            CL_LD, CL_ST: state <= MEM;
            CL_BR:        state <= FETCH;
            default:      state <= WB;
          endcase
        MEM:
          if (bus.dmem_ready)
            state <= (cur_cls == CL_LD) ? WB : FETCH;
        WB:
          state <= FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        TRAP:
          state <= TRAP;
`endif
        default:
          state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    instret_q <= '0;
    else if (ret) instret_q <= instret_q + ONE;
  end

  // Reset forces every output low so aborted accesses drop at once.
  always_comb begin
    req   = 1'b0;
    irw   = 1'b0;
    pcw   = 1'b0;
    src   = 1'b0;
    m2r   = 1'b0;
    rw    = 1'b0;
    mr    = 1'b0;
    mw    = 1'b0;
    brn   = 1'b0;
    ret   = 1'b0;
    ill   = 1'b0;
    aluop = ALUOP_ADD;
    if (!reset) begin
      case (state)
        FETCH: begin
          req = 1'b1;
          irw = bus.imem_ready;
          pcw = bus.imem_ready;
        end
        DECODE: begin
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
          ret = (new_cls == CL_ILL);
`endif
        end
        EXEC:
          case (cur_cls)
            CL_R: aluop = ALUOP_FUNCT;
            CL_I: begin
              aluop = ALUOP_FUNCT;
              src   = 1'b1;
            end
            CL_LD, CL_ST: src = 1'b1;
            CL_BR: begin
              aluop = ALUOP_BR;
              brn   = 1'b1;
              ret   = 1'b1;
            end
            default: ;
          endcase
        MEM: begin
          src = 1'b1;
          mr  = (cur_cls == CL_LD);
          mw  = (cur_cls == CL_ST);
          ret = (cur_cls == CL_ST) && bus.dmem_ready;
        end
        WB: begin
          rw    = 1'b1;
          ret   = 1'b1;
          m2r   = (cur_cls == CL_LD);
          src   = (cur_cls != CL_R);
          aluop = (cur_cls == CL_LD) ? ALUOP_ADD
                                     : ALUOP_FUNCT;
        end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        TRAP:
          ill = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.imem_req      = req;
  assign bus.IRWrite       = irw;
  assign bus.PCWrite       = pcw;
  assign bus.ALUSrc        = src;
  assign bus.MemtoReg      = m2r;
  assign bus.RegWrite      = rw;
  assign bus.MemRead       = mr;
  assign bus.MemWrite      = mw;
  assign bus.ALUOp         = aluop;
  assign bus.Branch        = brn;
  assign bus.retire        = ret;
  assign bus.instret       = instret_q;
  assign bus.illegal_instr = ill;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected traces built from
// instruction-level rules; a 2-bit-counter copy checks instret wrap.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  localparam logic [12:0] REQ = 13'h1000;
  localparam logic [12:0] IRW = 13'h0800;
  localparam logic [12:0] PCW = 13'h0400;
  localparam logic [12:0] SRC = 13'h0200;
  localparam logic [12:0] M2R = 13'h0100;
  localparam logic [12:0] RW  = 13'h0080;
  localparam logic [12:0] MR  = 13'h0040;
  localparam logic [12:0] MW  = 13'h0020;
  localparam logic [12:0] OPF = 13'h0010;
  localparam logic [12:0] OPB = 13'h0008;
  localparam logic [12:0] BRN = 13'h0004;
  localparam logic [12:0] RET = 13'h0002;
  localparam logic [12:0] ILL = 13'h0001;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        ir;
    logic        dr;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if #(.CNT_W(32)) bus ();
  multicycle_controller_if #(.CNT_W(2))  bus2 ();

  assign bus2.Opcode     = bus.Opcode;
  assign bus2.imem_ready = bus.imem_ready;
  assign bus2.dmem_ready = bus.dmem_ready;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  multicycle_controller #(.CNT_W(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  always #5 clk = ~clk;

  vec_t        q[$];
  vec_t        tbl[4];
  int          n_cmp = 0;
  int          n_err = 0;
  int          idx   = 0;
  logic [31:0] model = '0;
  bit          cnt_ok = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic push(input logic r, input logic [6:0] o,
                      input logic i, input logic d,
                      input logic [12:0] e);
    vec_t v;
    v.rst = r;
    v.opc = o;
    v.ir  = i;
    v.dr  = d;
    v.exp = e;
    q.push_back(v);
  endtask

  // abort: 0 none, 1 reset after fetch waits, 2 reset after mem waits
  task automatic gen(input logic [6:0] op, input int iw,
                     input int dw, input int abort);
    logic [12:0] acc;
    for (int k = 0; k < iw; k++) push(1'b0, ro(), 1'b0, 1'b1, REQ);
    if (abort == 1) begin
      push(1'b1, ro(), rb(), rb(), '0);
      return;
    end
    push(1'b0, ro(), 1'b1, rb(), REQ | IRW | PCW);
    case (op)
      OP_R: begin
        push(1'b0, op, rb(), rb(), '0);
        push(1'b0, ro(), rb(), rb(), OPF);
        push(1'b0, ro(), rb(), rb(), OPF | RW | RET);
      end
      OP_I: begin
        push(1'b0, op, rb(), rb(), '0);
        push(1'b0, ro(), rb(), rb(), OPF | SRC);
        push(1'b0, ro(), rb(), rb(), OPF | SRC | RW | RET);
      end
      OP_LW, OP_SW: begin
        acc = (op == OP_LW) ? MR : MW;
        push(1'b0, op, rb(), rb(), '0);
        push(1'b0, ro(), rb(), rb(), SRC);
        for (int k = 0; k < dw; k++)
          push(1'b0, ro(), 1'b1, 1'b0, SRC | acc);
        if (abort == 2) begin
          push(1'b1, ro(), rb(), rb(), '0);
          return;
        end
        if (op == OP_LW) begin
          push(1'b0, ro(), rb(), 1'b1, SRC | MR);
          push(1'b0, ro(), rb(), rb(), SRC | M2R | RW | RET);
        end else begin
          push(1'b0, ro(), rb(), 1'b1, SRC | MW | RET);
        end
      end
      OP_BR: begin
        push(1'b0, op, rb(), rb(), '0);
        push(1'b0, ro(), rb(), rb(), OPB | BRN | RET);
      end
      default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        push(1'b0, op, rb(), rb(), '0);
        for (int k = 0; k < 4; k++)
          push(1'b0, ro(), rb(), rb(), ILL);
        push(1'b1, ro(), rb(), rb(), '0);
`else
        push(1'b0, op, rb(), rb(), RET);
`endif
      end
    endcase
  endtask

  task automatic run_q();
    vec_t        v;
    logic [12:0] act;
    while (q.size() > 0) begin
      v = q.pop_front();
      reset          = v.rst;
      bus.Opcode     = v.opc;
      bus.imem_ready = v.ir;
      bus.dmem_ready = v.dr;
      @(negedge clk);
      act = {bus.imem_req, bus.IRWrite, bus.PCWrite,
             bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
             bus.MemRead, bus.MemWrite, bus.ALUOp,
             bus.Branch, bus.retire, bus.illegal_instr};
      n_cmp++;
      if (act !== v.exp) begin
        n_err++;
        $display("FAIL ctl cyc=%0d got=%b want=%b",
                 idx, act, v.exp);
      end
      if (cnt_ok) begin
        n_cmp++;
        if (bus.instret !== model) begin
          n_err++;
          $display("FAIL instret cyc=%0d got=%0d want=%0d",
                   idx, bus.instret, model);
        end
        n_cmp++;
        if (bus2.instret !== model[1:0]) begin
          n_err++;
          $display("FAIL wrap cyc=%0d got=%0d want=%0d",
                   idx, bus2.instret, model[1:0]);
        end
      end
      if (v.rst) begin
        model  = '0;
        cnt_ok = 1;
      end else if (v.exp[1]) begin
        model = model + 1;
      end
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] op;
    int         sel;
    reset          = 1'b1;
    bus.Opcode     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;

    tbl[0] = '{1'b0, 7'h55, 1'b1, 1'b1, REQ | IRW | PCW};
    tbl[1] = '{1'b0, OP_I,  1'b1, 1'b1, 13'h0};
    tbl[2] = '{1'b0, 7'h33, 1'b1, 1'b1, SRC | OPF};
    tbl[3] = '{1'b0, 7'h63, 1'b1, 1'b1,
               SRC | OPF | RW | RET};

    push(1'b1, ro(), 1'b1, 1'b1, '0);
    push(1'b1, ro(), 1'b1, 1'b1, '0);
    for (int i = 0; i < 4; i++) q.push_back(tbl[i]);
    run_q();

    gen(OP_LW, 0, 3, 0);
    gen(OP_SW, 0, 0, 0);
    gen(OP_BR, 0, 0, 0);
    gen(OP_I, 5, 0, 0);
    gen(7'h7f, 0, 0, 0);
    gen(OP_R, 1, 0, 0);
    gen(OP_LW, 0, 2, 2);
    gen(OP_SW, 1, 0, 0);
    gen(OP_R, 2, 0, 1);
    gen(OP_BR, 0, 0, 0);
    run_q();

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 10);
      case (sel)
        0, 1:    op = OP_R;
        2, 3:    op = OP_I;
        4, 5:    op = OP_LW;
        6, 7:    op = OP_SW;
        8, 9:    op = OP_BR;
        default: op = rb() ? 7'h7f : 7'h37;
      endcase
      if ($urandom_range(0, 14) == 0)
        gen(op, $urandom_range(0, 3), 0, 1);
      else
        gen(op, $urandom_range(0, 3),
            $urandom_range(0, 3), 0);
    end
    gen(OP_BR, 0, 0, 0);
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
